// File: rtl/jk_pkg.sv
// Shared types, constants and the per-bit JK excitation rule for the JK update controller.
package jk_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK
  } state_t;

  localparam int unsigned RETRY_W = 3;

  // Returns {J,K} moving one bit from q to t; unchanged bits are held (J0K0).
  function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic toggle);
    logic [1:0] jk;
    jk = 2'b00;
    if (q != t) begin
      if (toggle) jk = 2'b11;
      else        jk = t ? 2'b10 : 2'b01;
    end
    return jk;
  endfunction

endpackage

// File: rtl/jk_excite_bit.sv
// Combinational J/K excitation for a single bit of the external JK bank.
module jk_excite_bit
  import jk_pkg::*;
#(
  parameter bit TOGGLE_MODE = 1'b0
) (
  input  logic i_q,
  input  logic i_t,
  output logic o_j,
  output logic o_k
);

  logic [1:0] w_jk;

  assign w_jk = jk_excite(i_q, i_t, TOGGLE_MODE);
  assign o_j  = w_jk[1];
  assign o_k  = w_jk[0];

endmodule

// File: rtl/jk_excite_ctrl.sv
// Drives an external JK flip-flop bank towards a requested word, verifies the readback and re-drives on mismatch.
module jk_excite_ctrl
  import jk_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TOGGLE_MODE = 0,
  parameter int MAX_RETRY   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  input  logic [WIDTH-1:0] q_in,
  output logic             done,
  output logic             err,
  output logic [2:0]       retry_cnt
);

  localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRY);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_tgt, w_tgt_nxt;
  logic [WIDTH-1:0]   r_j, w_j_nxt;
  logic [WIDTH-1:0]   r_k, w_k_nxt;
  logic               r_done, w_done_nxt;
  logic               r_err, w_err_nxt;
  logic [RETRY_W-1:0] r_retry, w_retry_nxt;
  logic [WIDTH-1:0]   w_tgt_sel;
  logic [WIDTH-1:0]   w_j_calc;
  logic [WIDTH-1:0]   w_k_calc;

  // In IDLE the excitation is computed against the incoming word; on a retry, against the latched one.
  assign w_tgt_sel = (r_state == S_IDLE) ? tgt_data : r_tgt;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_excite_bit #(
      .TOGGLE_MODE(TOGGLE_MODE != 0)
    ) u_bit (
      .i_q(q_in[g]),
      .i_t(w_tgt_sel[g]),
      .o_j(w_j_calc[g]),
      .o_k(w_k_calc[g])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tgt_nxt   = r_tgt;
    w_j_nxt     = '0;
    w_k_nxt     = '0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_retry_nxt = r_retry;
    case (r_state)
      S_IDLE: begin
        if (tgt_valid) begin
          w_tgt_nxt   = tgt_data;
          w_retry_nxt = '0;
          w_j_nxt     = w_j_calc;
          w_k_nxt     = w_k_calc;
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE:  w_state_nxt = S_SETTLE;
      S_SETTLE: w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (q_in == r_tgt) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_retry < MAX_R) begin
          w_retry_nxt = r_retry + 1'b1;
          w_j_nxt     = w_j_calc;
          w_k_nxt     = w_k_calc;
          w_state_nxt = S_DRIVE;
        end else begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tgt   <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_retry <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tgt   <= w_tgt_nxt;
      r_j     <= w_j_nxt;
      r_k     <= w_k_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_retry <= w_retry_nxt;
    end
  end

  assign tgt_ready = (r_state == S_IDLE);
  assign j_out     = r_j;
  assign k_out     = r_k;
  assign done      = r_done;
  assign err       = r_err;
  assign retry_cnt = r_retry;

endmodule

// File: tb/tb_jk_excite_ctrl.sv
// Closed-loop bench: behavioural JK flip-flop banks driven by two controllers (set/reset and toggle encodings).
module tb_jk_excite_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid0, valid1;
  logic [7:0] data0, data1;
  logic       ready0, ready1;
  logic [7:0] j0, k0, j1, k1;
  logic [7:0] q0, q1;
  logic [7:0] bank0, bank1;
  logic [7:0] force_mask;
  logic       done0, err0, done1, err1;
  logic [2:0] retry0, retry1;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  assign q0 = bank0 & ~force_mask;
  assign q1 = bank1;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    if (j && k) return ~q;
    if (j)      return 1'b1;
    if (k)      return 1'b0;
    return q;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bank0 <= '0;
      bank1 <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        bank0[i] <= jk_next(bank0[i], j0[i], k0[i]);
        bank1[i] <= jk_next(bank1[i], j1[i], k1[i]);
      end
    end
  end

  jk_excite_ctrl #(.WIDTH(8), .TOGGLE_MODE(0), .MAX_RETRY(2)) u_dut0 (
    .clk(clk), .rst(rst), .tgt_valid(valid0), .tgt_ready(ready0), .tgt_data(data0),
    .j_out(j0), .k_out(k0), .q_in(q0), .done(done0), .err(err0), .retry_cnt(retry0)
  );

  jk_excite_ctrl #(.WIDTH(8), .TOGGLE_MODE(1), .MAX_RETRY(2)) u_dut1 (
    .clk(clk), .rst(rst), .tgt_valid(valid1), .tgt_ready(ready1), .tgt_data(data1),
    .j_out(j1), .k_out(k1), .q_in(q1), .done(done1), .err(err1), .retry_cnt(retry1)
  );

  task automatic accept0(input logic [7:0] d);
    @(negedge clk);
    valid0 = 1'b1;
    data0  = d;
    @(posedge clk);
    @(negedge clk);
    valid0 = 1'b0;
  endtask

  task automatic accept1(input logic [7:0] d);
    @(negedge clk);
    valid1 = 1'b1;
    data1  = d;
    @(posedge clk);
    @(negedge clk);
    valid1 = 1'b0;
  endtask

  task automatic test_reset;
    n_tests++;
    if ({ready0, j0, k0, done0, err0, retry0} !== {1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset0 got rdy=%b j=%h k=%h d=%b e=%b r=%0d", ready0, j0, k0, done0, err0, retry0);
    end
    n_tests++;
    if ({ready1, j1, k1, done1, err1, retry1} !== {1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset1 got rdy=%b j=%h k=%h d=%b e=%b r=%0d", ready1, j1, k1, done1, err1, retry1);
    end
  endtask

  task automatic test_set_reset;
    accept0(8'hA5);
    n_tests++;
    if ({j0, k0, ready0} !== {8'hA5, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL s1_drive got j=%h k=%h rdy=%b exp j=a5 k=00 rdy=0", j0, k0, ready0);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_tests++;
        if ({j0, k0} !== 16'h0000) begin
          n_fail++; $display("FAIL s1_hold got j=%h k=%h exp 00/00", j0, k0);
        end
      end
      if (c < 3) begin
        n_tests++;
        if (done0 !== 1'b0) begin n_fail++; $display("FAIL s1_early_done cycle %0d got %b exp 0", c, done0); end
      end
    end
    n_tests++;
    if ({done0, err0, bank0, retry0, ready0} !== {1'b1, 1'b0, 8'hA5, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL s1_done got d=%b e=%b bank=%h r=%0d rdy=%b exp 1 0 a5 0 1", done0, err0, bank0, retry0, ready0);
    end
    @(negedge clk);
    n_tests++;
    if (done0 !== 1'b0) begin n_fail++; $display("FAIL s1_pulse got %b exp 0", done0); end
  endtask

  task automatic test_toggle;
    accept1(8'hA5);
    repeat (3) @(negedge clk);
    n_tests++;
    if ({done1, bank1} !== {1'b1, 8'hA5}) begin
      n_fail++; $display("FAIL s2_pre got d=%b bank=%h exp 1 a5", done1, bank1);
    end
    accept1(8'h5A);
    n_tests++;
    if ({j1, k1} !== 16'hFFFF) begin
      n_fail++; $display("FAIL s2_drive got j=%h k=%h exp ff/ff", j1, k1);
    end
    @(negedge clk);
    n_tests++;
    if ({j1, k1} !== 16'h0000) begin
      n_fail++; $display("FAIL s2_hold got j=%h k=%h exp 00/00", j1, k1);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if ({done1, err1, bank1} !== {1'b1, 1'b0, 8'h5A}) begin
      n_fail++; $display("FAIL s2_done got d=%b e=%b bank=%h exp 1 0 5a", done1, err1, bank1);
    end
  endtask

  task automatic test_retry;
    force_mask = 8'h01;
    accept0(8'h01);
    n_tests++;
    if ({j0, k0} !== {8'h01, 8'hA4}) begin
      n_fail++; $display("FAIL s3_drive1 got j=%h k=%h exp 01/a4", j0, k0);
    end
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      n_tests++;
      if (done0 !== 1'b0) begin n_fail++; $display("FAIL s3_no_done cycle %0d got %b exp 0", c, done0); end
      n_tests++;
      if (err0 !== (c == 9)) begin n_fail++; $display("FAIL s3_err cycle %0d got %b exp %b", c, err0, c == 9); end
      if (c == 3 || c == 6) begin
        n_tests++;
        if ({j0, k0, retry0} !== {8'h01, 8'h00, 3'(c / 3)}) begin
          n_fail++; $display("FAIL s3_redrive cycle %0d got j=%h k=%h r=%0d exp 01 00 %0d", c, j0, k0, retry0, c / 3);
        end
      end
    end
    n_tests++;
    if ({retry0, ready0} !== {3'd2, 1'b1}) begin
      n_fail++; $display("FAIL s3_final got r=%0d rdy=%b exp 2 1", retry0, ready0);
    end
    force_mask = 8'h00;
    @(negedge clk);
    n_tests++;
    if (err0 !== 1'b0) begin n_fail++; $display("FAIL s3_pulse got %b exp 0", err0); end
  endtask

  task automatic test_equal;
    accept0(8'h3C);
    n_tests++;
    if ({j0, k0} !== {8'h3C, 8'h01}) begin
      n_fail++; $display("FAIL s4_pre got j=%h k=%h exp 3c/01", j0, k0);
    end
    repeat (3) @(negedge clk);
    accept0(8'h3C);
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) @(negedge clk);
      n_tests++;
      if ({j0, k0} !== 16'h0000) begin
        n_fail++; $display("FAIL s4_zero cycle %0d got j=%h k=%h exp 00/00", c, j0, k0);
      end
    end
    n_tests++;
    if ({done0, err0, bank0} !== {1'b1, 1'b0, 8'h3C}) begin
      n_fail++; $display("FAIL s4_done got d=%b e=%b bank=%h exp 1 0 3c", done0, err0, bank0);
    end
  endtask

  task automatic test_reset_mid;
    accept0(8'hF0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({j0, k0, ready0, done0, err0, retry0} !== {8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL s5_abort got j=%h k=%h rdy=%b d=%b e=%b r=%0d", j0, k0, ready0, done0, err0, retry0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if ({done0, err0} !== 2'b00) begin
        n_fail++; $display("FAIL s5_quiet cycle %0d got d=%b e=%b exp 0 0", c, done0, err0);
      end
    end
    accept0(8'h0F);
    n_tests++;
    if ({j0, k0} !== {8'h0F, 8'h00}) begin
      n_fail++; $display("FAIL s5_next_drive got j=%h k=%h exp 0f/00", j0, k0);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if ({done0, bank0} !== {1'b1, 8'h0F}) begin
      n_fail++; $display("FAIL s5_next_done got d=%b bank=%h exp 1 0f", done0, bank0);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    valid0 = 1'b1;
    data0  = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({j0, k0} !== {8'hF0, 8'h00}) begin
      n_fail++; $display("FAIL s6_drive got j=%h k=%h exp f0/00", j0, k0);
    end
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 4) valid0 = 1'b0;
      n_tests++;
      if (done0 !== (c == 3 || c == 7)) begin
        n_fail++; $display("FAIL s6_done cycle %0d got %b exp %b", c, done0, c == 3 || c == 7);
      end
      n_tests++;
      if (ready0 !== (c == 3 || c == 7)) begin
        n_fail++; $display("FAIL s6_ready cycle %0d got %b exp %b", c, ready0, c == 3 || c == 7);
      end
      if (c == 4) begin
        n_tests++;
        if ({j0, k0} !== 16'h0000) begin
          n_fail++; $display("FAIL s6_second_drive got j=%h k=%h exp 00/00", j0, k0);
        end
      end
    end
    n_tests++;
    if ({bank0, err0} !== {8'hFF, 1'b0}) begin
      n_fail++; $display("FAIL s6_bank got bank=%h e=%b exp ff 0", bank0, err0);
    end
  endtask

  initial begin
    valid0 = 1'b0; valid1 = 1'b0;
    data0 = '0; data1 = '0;
    force_mask = '0;
    #2 rst = 1'b1;
    #1 test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_set_reset();
    test_toggle();
    test_retry();
    test_equal();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
